priority_grant_arbiter: RTL
===========================

Name: priority_grant_arbiter

Overview:
- Sequential arbiter that shares one downstream resource among 8 requesters.
- Each cycle it uses the combinational priority-encode rule (highest asserted index wins) or a round-robin rule.
- Grants are held while the owner keeps requesting, up to a bounded hold time.
- Outputs are registered: one-hot grant vector, encoded grant index and a valid flag, for the top-level I/O wrapper.

Parameters:
- N, 8, number of requesters; fixed at 8 in this revision.
- IDX_W, 3, width of the grant index, log2(N).
- MAX_HOLD, 15, maximum consecutive cycles one owner may hold a grant; legal range 1..255.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- req  input  8  request vector; bit i = requester i wants the resource; level-sensitive.
- arb_en  input  1  1 = new grants may be issued; 0 = no new grants are issued.
- rr_mode  input  1  0 = fixed priority (highest index wins); 1 = round-robin.
- gnt  output  8  one-hot grant, or all-zero when idle; registered.
- gnt_idx  output  3  index of current owner; registered.
- gnt_valid  output  1  1 while any grant is held; registered, equals |gnt.

Behaviour:
- Reset (async assert, sync release): state=IDLE, gnt=0, gnt_idx=0, gnt_valid=0, hold_cnt=0, last_owner=N-1.
- State machine: IDLE and GRANT.
- IDLE -> GRANT when arb_en=1 and req!=0:
  - winner is computed from req in the current cycle;
  - gnt, gnt_idx and gnt_valid update on the same edge, so latency is 1 cycle from req to gnt;
  - hold_cnt is set to 1 and last_owner is set to the winner.
- IDLE with req=0 or arb_en=0: stay in IDLE with outputs 0.
- GRANT, hold condition: req[owner]=1 and hold_cnt<MAX_HOLD. Stay in GRANT, hold_cnt+1, outputs unchanged.
- GRANT, release conditions:
  - drop: req[owner]=0, or
  - timeout: hold_cnt==MAX_HOLD.
- Release handling, on the same edge (zero-bubble handover):
  - candidates = req with the owner bit masked on timeout; on drop the owner bit is already 0;
  - if arb_en=1 and candidates!=0: grant the winner, hold_cnt=1, last_owner=winner, stay in GRANT;
  - timeout with only the owner requesting: the owner is re-granted, hold_cnt=1, gnt stays constant;
  - otherwise: go to IDLE, gnt=0, gnt_valid=0, gnt_idx holds its last value.
- arb_en=0 while in GRANT does not revoke the current grant. The grant ends only at the next release.
- Fixed mode winner: highest-index set bit of the candidates.
- Round-robin winner: first set bit scanning ascending from (last_owner+1) mod 8, wrapping 7->0. After reset the scan starts at index 0.
- rr_mode is sampled only at arbitration edges (IDLE->GRANT or release). A change mid-hold has no effect until the next arbitration.
- Invariants:
  - gnt is always one-hot or zero;
  - gnt[gnt_idx]=1 whenever gnt_valid=1;
  - hold_cnt never exceeds MAX_HOLD and saturation never wraps.
- Reset mid-grant: all outputs go to 0 immediately, without waiting for a clock edge. last_owner returns to N-1.

Test Plan:
- Reset: assert rst_n=0 with req=8'hFF mid-grant -> gnt=0, gnt_valid=0 and gnt_idx=0 asynchronously; after release with req=8'h00, outputs stay 0.
- Fixed priority: rr_mode=0, req=8'b0010_0110 -> after 1 edge gnt=8'b0010_0000, gnt_idx=5; drop req[5] -> next edge gnt=8'b0000_0100, gnt_idx=2, with no idle cycle.
- Timeout: MAX_HOLD=4, rr_mode=0, req=8'b1000_0001 held -> gnt_idx=7 for 4 cycles, then 0 for 4 cycles, alternating. With req=8'h80 only -> gnt_idx=7 continuously, gnt never drops.
- Round-robin: rr_mode=1, req=8'hFF, each owner drops req for 1 cycle after its grant then reasserts -> grant order 0,1,2,...,7,0.
- arb_en gating: grant to 3 active, arb_en=0 -> grant to 3 persists until req[3]=0, then gnt=0 despite other requests; arb_en=1 -> winner granted 1 cycle later.
- Mode switch mid-hold: owner 6, toggle rr_mode 0->1 during the hold -> no change until release; the next winner follows round-robin from index 7.

Source files
------------

// File: rtl/priority_grant_arbiter.sv
// Purpose : share one downstream resource among N requesters, fixed-priority or round-robin, with bounded hold.
// Latency : 1 cycle from req to registered gnt; handover on release is zero-bubble.
// Backpressure: none; req is level-sensitive, arb_en only gates new grants, it never revokes a held one.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req[N-1:0]            level-sensitive request vector
//   arb_en                1 = new grants may be issued
//   rr_mode               0 = highest index wins, 1 = round-robin after last owner
//   gnt[N-1:0]            registered one-hot grant (zero when idle)
//   gnt_idx[IDX_W-1:0]    registered index of current/last owner
//   gnt_valid             registered, high while a grant is held
module priority_grant_arbiter #(
    parameter int N        = 8,
    parameter int IDX_W    = 3,
    parameter int MAX_HOLD = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic             arb_en,
    input  logic             rr_mode,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid
);

    typedef enum logic {ST_IDLE = 1'b0, ST_GRANT = 1'b1} state_t;

    localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

    state_t           r_state;
    logic [N-1:0]     r_gnt;
    logic [IDX_W-1:0] r_gnt_idx;
    logic [7:0]       r_hold;
    logic [IDX_W-1:0] r_last_owner;

    state_t           w_state_nxt;
    logic [N-1:0]     w_gnt_nxt;
    logic [IDX_W-1:0] w_idx_nxt;
    logic [7:0]       w_hold_nxt;
    logic [IDX_W-1:0] w_last_nxt;

    logic [N-1:0]     w_owner_oh;
    logic             w_owner_req;
    logic             w_timeout;
    logic [N-1:0]     w_cand;
    logic [IDX_W-1:0] w_fp_win;
    logic [IDX_W-1:0] w_rr_start;
    logic [IDX_W-1:0] w_rr_win;
    logic [IDX_W-1:0] w_win;
    logic [N-1:0]     w_win_oh;

    // Candidate set and both winners. On timeout the owner is masked so the
    // others get a turn; on drop its request bit is already clear.
    always_comb begin
        w_owner_oh  = N'(1) << r_gnt_idx;
        w_owner_req = |(req & w_owner_oh);
        w_timeout   = (r_state == ST_GRANT) && (r_hold == HOLD_MAX);
        w_cand      = w_timeout ? (req & ~w_owner_oh) : req;

        // Ascending scan: the last set bit seen is the highest index.
        w_fp_win = '0;
        for (int i = 0; i < N; i++) begin
            if (w_cand[i]) w_fp_win = IDX_W'(i);
        end

        // Descending offset scan: the last hit is the smallest offset from
        // the slot after the previous owner, i.e. the first in RR order.
        w_rr_start = r_last_owner + 1'b1;
        w_rr_win   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_cand[w_rr_start + IDX_W'(k)]) w_rr_win = w_rr_start + IDX_W'(k);
        end

        // rr_mode only matters on arbitration edges because w_win is only
        // consumed there.
        w_win    = rr_mode ? w_rr_win : w_fp_win;
        w_win_oh = N'(1) << w_win;
    end

    // State register (also holds the registered outputs and counters).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_gnt        <= '0;
            r_gnt_idx    <= '0;
            r_hold       <= '0;
            r_last_owner <= IDX_W'(N - 1);
        end else begin
            r_state      <= w_state_nxt;
            r_gnt        <= w_gnt_nxt;
            r_gnt_idx    <= w_idx_nxt;
            r_hold       <= w_hold_nxt;
            r_last_owner <= w_last_nxt;
        end
    end

    // Next-state and next-datapath logic.
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_idx_nxt   = r_gnt_idx;
        w_hold_nxt  = r_hold;
        w_last_nxt  = r_last_owner;

        case (r_state)
            ST_IDLE: begin
                if (arb_en && (|req)) begin
                    w_state_nxt = ST_GRANT;
                    w_gnt_nxt   = w_win_oh;
                    w_idx_nxt   = w_win;
                    w_hold_nxt  = 8'd1;
                    w_last_nxt  = w_win;
                end
            end
            ST_GRANT: begin
                if (w_owner_req && !w_timeout) begin
                    w_hold_nxt = r_hold + 8'd1;
                end else if (arb_en && (|w_cand)) begin
                    w_gnt_nxt  = w_win_oh;
                    w_idx_nxt  = w_win;
                    w_hold_nxt = 8'd1;
                    w_last_nxt = w_win;
                end else if (arb_en && w_timeout && w_owner_req) begin
                    // Sole requester timed out: restart its hold window,
                    // grant vector stays the same.
                    w_hold_nxt = 8'd1;
                    w_last_nxt = r_gnt_idx;
                end else begin
                    // gnt_idx keeps the last owner while idle.
                    w_state_nxt = ST_IDLE;
                    w_gnt_nxt   = '0;
                    w_hold_nxt  = '0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_gnt_nxt   = '0;
                w_hold_nxt  = '0;
            end
        endcase
    end

    // Output logic.
    always_comb begin
        gnt       = r_gnt;
        gnt_idx   = r_gnt_idx;
        gnt_valid = (r_state == ST_GRANT);
    end

endmodule
